alu_share_ctrl: RTL and testbench

Sequencer/arbiter that shares the single combinational 4-bit ALU between two requesters, e.g. the switch/button front end and the self-test sequencer. It accepts one operation at a time through valid/ready, screens illegal requests, drives the ALU's a/b/op/start inputs, and captures the result nibble and the NZCV flags. It returns them on a shared response channel and keeps completed/error op counters. It sits between the requesters and the ALU; the 7-segment path stays on the ALU side.

---
 rtl/alu_ctrl_pkg.sv | 33 +++
 rtl/rr_arbiter2.sv | 18 +
 rtl/alu_share_ctrl.sv | 155 +++++++++++++++
 tb/tb_alu_share_ctrl.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_ctrl_pkg.sv
// Shared types and constants for the shared-ALU controller.
package alu_ctrl_pkg;

    typedef enum logic [3:0] {
        OP_ADD = 4'd1,
        OP_SUB = 4'd2,
        OP_MUL = 4'd3,
        OP_DIV = 4'd4,
        OP_AND = 4'd5,
        OP_OR  = 4'd6,
        OP_XOR = 4'd7,
        OP_SHL = 4'd8,
        OP_SHR = 4'd9
    } op_e;

    // Bit positions inside the {N,Z,C,V} flag nibble.
    localparam int unsigned FLG_N = 3;
    localparam int unsigned FLG_Z = 2;
    localparam int unsigned FLG_C = 1;
    localparam int unsigned FLG_V = 0;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        RESP
    } state_e;

    // Requests the ALU cannot execute: unknown opcodes and divide by zero.
    function automatic logic op_illegal(input logic [3:0] op, input logic [3:0] b);
        return (op == 4'd0) || (op > OP_SHR) || ((op == OP_DIV) && (b == '0));
    endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter: on a tie the requester that was not served last wins.
module rr_arbiter2 (
    input  logic [1:0] req_i,
    input  logic       last_grant_i,
    output logic [1:0] grant_o
);

    // One-hot grant; requester 0 wins ties when requester 1 was served last.
    always_comb begin
        grant_o = '0;
        if (req_i[0] && (!req_i[1] || last_grant_i)) begin
            grant_o[0] = 1'b1;
        end else if (req_i[1]) begin
            grant_o[1] = 1'b1;
        end
    end

endmodule

// File: rtl/alu_share_ctrl.sv
// Sequencer sharing one combinational 4-bit ALU between two requesters,
// with request screening, registered response channel and op/error counters.
module alu_share_ctrl
    import alu_ctrl_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES = 1,
    parameter int unsigned CNT_W         = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [3:0]       req0_a,
    input  logic [3:0]       req0_b,
    input  logic [3:0]       req0_op,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [3:0]       req1_a,
    input  logic [3:0]       req1_b,
    input  logic [3:0]       req1_op,
    output logic [3:0]       alu_a,
    output logic [3:0]       alu_b,
    output logic [3:0]       alu_op,
    output logic             alu_start,
    input  logic [3:0]       alu_result,
    input  logic [3:0]       alu_flags,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [3:0]       rsp_result,
    output logic [3:0]       rsp_flags,
    output logic             rsp_err,
    output logic [CNT_W-1:0] op_count,
    output logic [CNT_W-1:0] err_count
);

    localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES - 1);

    state_e           state_q;
    logic             last_grant_q;
    logic [3:0]       settle_q;
    logic [3:0]       alu_a_q;
    logic [3:0]       alu_b_q;
    logic [3:0]       alu_op_q;
    logic             alu_start_q;
    logic             rsp_valid_q;
    logic             rsp_id_q;
    logic [3:0]       rsp_result_q;
    logic [3:0]       rsp_flags_q;
    logic             rsp_err_q;
    logic [CNT_W-1:0] op_count_q;
    logic [CNT_W-1:0] err_count_q;

    logic [1:0] grant;
    logic       accept;
    logic       sel_id;
    logic [3:0] sel_a;
    logic [3:0] sel_b;
    logic [3:0] sel_op;

    rr_arbiter2 u_arb (
        .req_i        ({req1_valid, req0_valid}),
        .last_grant_i (last_grant_q),
        .grant_o      (grant)
    );

    assign req0_ready = !rst && (state_q == IDLE) && grant[0];
    assign req1_ready = !rst && (state_q == IDLE) && grant[1];
    assign accept     = req0_ready || req1_ready;
    assign sel_id     = grant[1];
    assign sel_a      = sel_id ? req1_a  : req0_a;
    assign sel_b      = sel_id ? req1_b  : req0_b;
    assign sel_op     = sel_id ? req1_op : req0_op;

    // Control FSM: accept/screen in IDLE, hold alu_start in ISSUE, present response in RESP.
    // ALU operand registers load only on a legal accept so the ALU inputs never move while start is low.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
            settle_q     <= '0;
            alu_a_q      <= '0;
            alu_b_q      <= '0;
            alu_op_q     <= '0;
            alu_start_q  <= 1'b0;
            rsp_valid_q  <= 1'b0;
            rsp_id_q     <= 1'b0;
            rsp_result_q <= '0;
            rsp_flags_q  <= '0;
            rsp_err_q    <= 1'b0;
            op_count_q   <= '0;
            err_count_q  <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        rsp_id_q <= sel_id;
                        if (op_illegal(sel_op, sel_b)) begin
                            rsp_err_q    <= 1'b1;
                            rsp_result_q <= '0;
                            rsp_flags_q  <= '0;
                            rsp_valid_q  <= 1'b1;
                            state_q      <= RESP;
                        end else begin
                            rsp_err_q   <= 1'b0;
                            alu_a_q     <= sel_a;
                            alu_b_q     <= sel_b;
                            alu_op_q    <= sel_op;
                            alu_start_q <= 1'b1;
                            settle_q    <= '0;
                            state_q     <= ISSUE;
                        end
                    end
                end
                ISSUE: begin
                    if (settle_q == SETTLE_LAST) begin
                        rsp_result_q <= alu_result;
                        rsp_flags_q  <= alu_flags;
                        alu_start_q  <= 1'b0;
                        rsp_valid_q  <= 1'b1;
                        state_q      <= RESP;
                    end else begin
                        settle_q <= settle_q + 4'd1;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid_q  <= 1'b0;
                        last_grant_q <= rsp_id_q;
                        if (rsp_err_q) begin
                            err_count_q <= err_count_q + CNT_W'(1);
                        end else begin
                            op_count_q <= op_count_q + CNT_W'(1);
                        end
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign alu_a      = alu_a_q;
    assign alu_b      = alu_b_q;
    assign alu_op     = alu_op_q;
    assign alu_start  = alu_start_q;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_id     = rsp_id_q;
    assign rsp_result = rsp_result_q;
    assign rsp_flags  = rsp_flags_q;
    assign rsp_err    = rsp_err_q;
    assign op_count   = op_count_q;
    assign err_count  = err_count_q;

endmodule

// File: tb/tb_alu_share_ctrl.sv
// Directed bench for alu_share_ctrl: one instance with one settle cycle, one with four.
module tb_alu_share_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int checks = 0;
    int fails  = 0;

    // Stand-in for the external ALU: {N,Z,C,V, result}.
    function automatic logic [7:0] alu_model(input logic [3:0] a, input logic [3:0] b, input logic [3:0] op);
        logic [4:0] w;
        logic [3:0] r;
        logic c, v;
        w = '0; r = a; c = 1'b0; v = 1'b0;
        case (op)
            4'd1: begin w = {1'b0, a} + {1'b0, b}; r = w[3:0]; c = w[4];
                        v = (a[3] == b[3]) && (r[3] != a[3]); end
            4'd2: begin r = a - b; c = (a >= b); v = (a[3] != b[3]) && (r[3] != a[3]); end
            4'd5: r = a & b;
            4'd6: r = a | b;
            4'd7: r = a ^ b;
            default: r = a;
        endcase
        return {r[3], (r == 4'd0), c, v, r};
    endfunction

    // Instance with SETTLE_CYCLES=1
    logic       r0v = 0, r1v = 0, r0rdy, r1rdy;
    logic [3:0] r0a = 0, r0b = 0, r0op = 0, r1a = 0, r1b = 0, r1op = 0;
    logic [3:0] aa, ab, aop, ares, aflg;
    logic       astart, rv, rrdy = 0, rid, rerr;
    logic [3:0] rres, rflg;
    logic [7:0] opc, errc;
    logic [7:0] m1;
    assign m1   = alu_model(aa, ab, aop);
    assign ares = m1[3:0];
    assign aflg = m1[7:4];

    alu_share_ctrl #(.SETTLE_CYCLES(1), .CNT_W(8)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(r0v), .req0_ready(r0rdy), .req0_a(r0a), .req0_b(r0b), .req0_op(r0op),
        .req1_valid(r1v), .req1_ready(r1rdy), .req1_a(r1a), .req1_b(r1b), .req1_op(r1op),
        .alu_a(aa), .alu_b(ab), .alu_op(aop), .alu_start(astart),
        .alu_result(ares), .alu_flags(aflg),
        .rsp_valid(rv), .rsp_ready(rrdy), .rsp_id(rid), .rsp_result(rres), .rsp_flags(rflg),
        .rsp_err(rerr), .op_count(opc), .err_count(errc)
    );

    // Instance with SETTLE_CYCLES=4 (requester 1 unused)
    logic       s0v = 0, s0rdy, s1rdy;
    logic [3:0] s0a = 0, s0b = 0, s0op = 0;
    logic [3:0] sa, sb, sop, sres, sflg;
    logic       sstart, sv, srdy = 0, sid, serr;
    logic [3:0] sr, sf;
    logic [7:0] sopc, serrc;
    logic [7:0] m4;
    assign m4   = alu_model(sa, sb, sop);
    assign sres = m4[3:0];
    assign sflg = m4[7:4];

    alu_share_ctrl #(.SETTLE_CYCLES(4), .CNT_W(8)) dut4 (
        .clk(clk), .rst(rst),
        .req0_valid(s0v), .req0_ready(s0rdy), .req0_a(s0a), .req0_b(s0b), .req0_op(s0op),
        .req1_valid(1'b0), .req1_ready(s1rdy), .req1_a(4'd0), .req1_b(4'd0), .req1_op(4'd0),
        .alu_a(sa), .alu_b(sb), .alu_op(sop), .alu_start(sstart),
        .alu_result(sres), .alu_flags(sflg),
        .rsp_valid(sv), .rsp_ready(srdy), .rsp_id(sid), .rsp_result(sr), .rsp_flags(sf),
        .rsp_err(serr), .op_count(sopc), .err_count(serrc)
    );

    // Inputs change right after the falling edge; outputs are read 1ns later.
    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cyc(); cyc();
        rst = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({r0rdy, r1rdy, astart, aa, ab, aop, rv, rid, rres, rflg, rerr} !== '0) begin
            fails++; $display("FAIL reset_outputs: got nonzero ready/alu/rsp outputs");
        end
        checks++;
        if (opc !== 8'd0 || errc !== 8'd0) begin
            fails++; $display("FAIL reset_counters: op=%0d err=%0d required 0/0", opc, errc);
        end
    endtask

    task automatic test_basic_add();
        cyc(); r0v = 1; r0a = 4'd3; r0b = 4'd4; r0op = 4'd1; #1;
        checks++;
        if (r0rdy !== 1'b1 || astart !== 1'b0) begin
            fails++; $display("FAIL add_accept: ready=%b start=%b required 1/0", r0rdy, astart);
        end
        cyc(); r0v = 0; #1;
        checks++;
        if (astart !== 1'b1 || aa !== 4'd3 || ab !== 4'd4 || aop !== 4'd1 || rv !== 1'b0) begin
            fails++; $display("FAIL add_issue: start=%b a=%h b=%h op=%h rv=%b required 1/3/4/1/0", astart, aa, ab, aop, rv);
        end
        cyc(); #1;
        checks++;
        if (astart !== 1'b0 || rv !== 1'b1 || rid !== 1'b0 || rres !== 4'd7 || rflg !== 4'b0000 || rerr !== 1'b0) begin
            fails++; $display("FAIL add_rsp: start=%b rv=%b id=%b res=%h flg=%b err=%b required 0/1/0/7/0000/0", astart, rv, rid, rres, rflg, rerr);
        end
        rrdy = 1;
        cyc(); rrdy = 0; #1;
        checks++;
        if (rv !== 1'b0 || opc !== 8'd1 || errc !== 8'd0) begin
            fails++; $display("FAIL add_count: rv=%b op=%0d err=%0d required 0/1/0", rv, opc, errc);
        end
    endtask

    task automatic test_arbitration();
        logic [3:0] exp_res [4] = '{4'd3, 4'd8, 4'd3, 4'd8};
        logic       exp_id  [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
        do_reset();
        for (int round = 0; round < 2; round++) begin
            cyc();
            r0v = 1; r0a = 4'd5; r0b = 4'd2; r0op = 4'd2;
            r1v = 1; r1a = 4'hC; r1b = 4'hA; r1op = 4'd5; #1;
            checks++;
            if (r0rdy !== 1'b1 || r1rdy !== 1'b0) begin
                fails++; $display("FAIL arb_tie_round%0d: r0rdy=%b r1rdy=%b required 1/0", round, r0rdy, r1rdy);
            end
            for (int k = 0; k < 2; k++) begin
                if (k == 1) begin
                    #1;
                    checks++;
                    if (r1rdy !== 1'b1) begin
                        fails++; $display("FAIL arb_second_grant: r1rdy=%b required 1", r1rdy);
                    end
                end
                cyc();
                if (k == 0) r0v = 0; else r1v = 0;
                #1;
                checks++;
                if (r1rdy !== 1'b0) begin
                    fails++; $display("FAIL arb_busy_ready: r1rdy=%b required 0", r1rdy);
                end
                cyc(); #1;
                checks++;
                if (rv !== 1'b1 || rid !== exp_id[round*2+k] || rres !== exp_res[round*2+k]) begin
                    fails++; $display("FAIL arb_rsp%0d: rv=%b id=%b res=%h required 1/%b/%h", round*2+k, rv, rid, rres, exp_id[round*2+k], exp_res[round*2+k]);
                end
                if (k == 1) begin
                    checks++;
                    if (rflg !== 4'b1000) begin
                        fails++; $display("FAIL and_flags: flg=%b required 1000", rflg);
                    end
                end
                rrdy = 1;
                cyc(); rrdy = 0;
            end
        end
        #1;
        checks++;
        if (opc !== 8'd4) begin
            fails++; $display("FAIL arb_count: op=%0d required 4", opc);
        end
    endtask

    task automatic test_div_zero();
        r1v = 1; r1a = 4'd9; r1b = 4'd0; r1op = 4'd4; #1;
        checks++;
        if (r1rdy !== 1'b1) begin
            fails++; $display("FAIL div0_accept: r1rdy=%b required 1", r1rdy);
        end
        cyc(); r1v = 0; #1;
        checks++;
        if (rv !== 1'b1 || rerr !== 1'b1 || rres !== 4'd0 || rflg !== 4'd0 || rid !== 1'b1 || astart !== 1'b0) begin
            fails++; $display("FAIL div0_rsp: rv=%b err=%b res=%h flg=%b id=%b start=%b required 1/1/0/0000/1/0", rv, rerr, rres, rflg, rid, astart);
        end
        rrdy = 1;
        cyc(); rrdy = 0; #1;
        checks++;
        if (rv !== 1'b0 || errc !== 8'd1 || opc !== 8'd4 || astart !== 1'b0) begin
            fails++; $display("FAIL div0_count: rv=%b err=%0d op=%0d start=%b required 0/1/4/0", rv, errc, opc, astart);
        end
    endtask

    task automatic test_bad_opcodes();
        logic [3:0] bad [2] = '{4'hF, 4'h0};
        do_reset();
        for (int i = 0; i < 2; i++) begin
            cyc(); r0v = 1; r0a = 4'd1; r0b = 4'd1; r0op = bad[i];
            cyc(); r0v = 0; #1;
            checks++;
            if (rv !== 1'b1 || rerr !== 1'b1 || astart !== 1'b0) begin
                fails++; $display("FAIL badop_%h: rv=%b err=%b start=%b required 1/1/0", bad[i], rv, rerr, astart);
            end
            rrdy = 1;
            cyc(); rrdy = 0;
        end
        #1;
        checks++;
        if (errc !== 8'd2 || opc !== 8'd0) begin
            fails++; $display("FAIL badop_count: err=%0d op=%0d required 2/0", errc, opc);
        end
    endtask

    task automatic test_back_to_back();
        cyc(); r0v = 1; r0a = 4'd9; r0b = 4'd9; r0op = 4'd1;
        cyc(); r0v = 0; r1v = 1; r1a = 4'd1; r1b = 4'd1; r1op = 4'd1;
        cyc();
        for (int i = 0; i < 5; i++) begin
            #1;
            checks++;
            if (rv !== 1'b1 || rres !== 4'd2 || rflg !== 4'b0011 || rid !== 1'b0 || rerr !== 1'b0 || r1rdy !== 1'b0) begin
                fails++; $display("FAIL hold_cycle%0d: rv=%b res=%h flg=%b id=%b err=%b r1rdy=%b required 1/2/0011/0/0/0", i, rv, rres, rflg, rid, rerr, r1rdy);
            end
            cyc();
        end
        rrdy = 1;
        cyc(); rrdy = 0; #1;
        checks++;
        if (rv !== 1'b0 || r1rdy !== 1'b1) begin
            fails++; $display("FAIL hold_release: rv=%b r1rdy=%b required 0/1", rv, r1rdy);
        end
        cyc(); r1v = 0;
        cyc(); #1;
        checks++;
        if (rv !== 1'b1 || rid !== 1'b1 || rres !== 4'd2 || rflg !== 4'b0000) begin
            fails++; $display("FAIL hold_next: rv=%b id=%b res=%h flg=%b required 1/1/2/0000", rv, rid, rres, rflg);
        end
        rrdy = 1;
        cyc(); rrdy = 0;
    endtask

    task automatic test_reset_mid_issue();
        cyc(); s0v = 1; s0a = 4'd3; s0b = 4'd4; s0op = 4'd1;
        cyc(); s0v = 0;
        cyc(); rst = 1'b1;
        cyc(); #1;
        checks++;
        if ({s0rdy, sstart, sa, sb, sop, sv, sr, sf, serr, sopc, serrc} !== '0) begin
            fails++; $display("FAIL midreset: start=%b a=%h rv=%b op=%0d err=%0d required all 0", sstart, sa, sv, sopc, serrc);
        end
        rst = 1'b0;
        cyc(); s0v = 1; s0a = 4'd1; s0b = 4'd2; s0op = 4'd1;
        for (int i = 0; i < 4; i++) begin
            cyc(); s0v = 0; #1;
            checks++;
            if (sstart !== 1'b1 || sv !== 1'b0) begin
                fails++; $display("FAIL s4_issue%0d: start=%b rv=%b required 1/0", i, sstart, sv);
            end
        end
        cyc(); #1;
        checks++;
        if (sstart !== 1'b0 || sv !== 1'b1 || sr !== 4'd3 || serr !== 1'b0) begin
            fails++; $display("FAIL s4_rsp: start=%b rv=%b res=%h err=%b required 0/1/3/0", sstart, sv, sr, serr);
        end
        srdy = 1;
        cyc(); srdy = 0; #1;
        checks++;
        if (sopc !== 8'd1 || sv !== 1'b0) begin
            fails++; $display("FAIL s4_count: op=%0d rv=%b required 1/0", sopc, sv);
        end
    endtask

    initial begin
        test_reset();
        test_basic_add();
        test_arbitration();
        test_div_zero();
        test_bad_opcodes();
        test_back_to_back();
        test_reset_mid_issue();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
